// File: rtl/hp_bus_rx_ctrl_pkg.sv
// Shared definitions for the HP859x display-cable receive controller:
// default data width and the FSM state encoding.
package hp_bus_rx_ctrl_pkg;

  // Cable data bits, excluding the fixed-zero LSB
  localparam int HP_DW = 14;

  // Handshake FSM states, 3-bit encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_READY    = 3'd1;
  localparam logic [2:0] ST_SETTLE   = 3'd2;
  localparam logic [2:0] ST_CAPTURE  = 3'd3;
  localparam logic [2:0] ST_WAIT_REL = 3'd4;

  // LRFD is asserted only while we are waiting for, or settling, a word
  function automatic logic lrfd_for_state(input logic [2:0] st);
    return (st == ST_READY) || (st == ST_SETTLE);
  endfunction

endpackage

// File: rtl/hp_word_fifo.sv
// Small synchronous show-ahead FIFO. dout always shows the head word
// (zero when empty). Simultaneous push and pop are both honoured; pop
// when empty is ignored, and push when full is dropped unless a pop
// frees the slot in the same cycle.
module hp_word_fifo #(
  parameter int DW    = 14,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              din,
  output logic [DW-1:0]              dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign count   = cnt;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/hp_bus_rx_ctrl.sv
// Receive-side LDAV/LRFD handshake controller for the HP859x display cable.
// Synchronises LDAV, raises LRFD when there is room, waits for the data to
// settle after LDAV, captures one word into a show-ahead FIFO and then waits
// for LDAV to be released. Downstream handshake: a word transfers on any
// clock edge where m_valid and m_ready are both high; m_valid stays high and
// m_data stays stable until that happens.
module hp_bus_rx_ctrl
  import hp_bus_rx_ctrl_pkg::*;
#(
  parameter int DW          = HP_DW,
  parameter int DEPTH       = 4,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic          CLOCK_50,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          ldav,
  output logic          lrfd,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [15:0]   word_cnt,
  output logic          timeout_err,
  input  logic          err_clr,
  output logic          busy
);

  localparam int SW = (SETTLE_CYC  > 1) ? $clog2(SETTLE_CYC)      : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          ldav_s1;
  logic          ldav_s;
  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          push;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_cnt;
  logic          has_space;

  assign push      = (state == ST_CAPTURE);
  assign has_space = !fifo_full && (fifo_cnt < CW'(DEPTH));
  assign tmo_hit   = (state == ST_WAIT_REL) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign busy      = (state != ST_IDLE);
  assign m_valid   = !fifo_empty;

  // Two-flop synchroniser for the asynchronous cable LDAV
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      ldav_s1 <= 1'b0;
      ldav_s  <= 1'b0;
    end else begin
      ldav_s1 <= ldav;
      ldav_s  <= ldav_s1;
    end
  end

  // Next-state logic of the handshake FSM
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (enable && has_space && !ldav_s) state_nxt = ST_READY;
      ST_READY:    if (ldav_s) state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (!ldav_s)                                state_nxt = ST_READY;
        else if (settle_cnt == SW'(SETTLE_CYC - 1)) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE:  state_nxt = ST_WAIT_REL;
      ST_WAIT_REL: if (!ldav_s) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered LRFD, derived from the state being entered
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      lrfd  <= 1'b0;
    end else begin
      state <= state_nxt;
      lrfd  <= lrfd_for_state(state_nxt);
    end
  end

  // Settle counter: cleared outside SETTLE, counts cycles spent in SETTLE
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n)                   settle_cnt <= '0;
    else if (state != ST_SETTLE)  settle_cnt <= '0;
    else                          settle_cnt <= settle_cnt + 1'b1;
  end

  // Release timeout counter: runs in WAIT_REL and saturates, so the error sets once per word
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n)                        tmo_cnt <= '0;
    else if (state != ST_WAIT_REL)     tmo_cnt <= '0;
    else if (tmo_cnt != TW'(TIMEOUT_CYC)) tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Sticky timeout flag; a timeout in the same cycle as err_clr keeps it set
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n)       timeout_err <= 1'b0;
    else if (tmo_hit) timeout_err <= 1'b1;
    else if (err_clr) timeout_err <= 1'b0;
  end

  // Captured-word counter, wraps at 16 bits
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n)    word_cnt <= '0;
    else if (push) word_cnt <= word_cnt + 16'd1;
  end

  hp_word_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst_n (rst_n),
    .push  (push),
    .pop   (m_ready),
    .din   (data_in),
    .dout  (m_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_cnt)
  );

endmodule

// File: tb/tb_hp_bus_rx_ctrl.sv
// Bench for hp_bus_rx_ctrl: directed scenarios followed by a randomized
// word/pop mix, checked against a queue-based model of the cable handshake.
module tb_hp_bus_rx_ctrl;

  localparam int DW          = 14;
  localparam int DEPTH       = 4;
  localparam int SETTLE_CYC  = 8;
  localparam int TIMEOUT_CYC = 100;
  localparam int CAP_LAT     = 2 + SETTLE_CYC + 1;

  logic          CLOCK_50 = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          ldav;
  logic          lrfd;
  logic [DW-1:0] data_in;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [15:0]   word_cnt;
  logic          timeout_err;
  logic          err_clr;
  logic          busy;

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [15:0]   exp_cnt;

  hp_bus_rx_ctrl #(
    .DW          (DW),
    .DEPTH       (DEPTH),
    .SETTLE_CYC  (SETTLE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .rst_n       (rst_n),
    .enable      (enable),
    .ldav        (ldav),
    .lrfd        (lrfd),
    .data_in     (data_in),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .word_cnt    (word_cnt),
    .timeout_err (timeout_err),
    .err_clr     (err_clr),
    .busy        (busy)
  );

  // Clock and overall time limit
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #3_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_lrfd(input logic val, input string tag);
    int n = 0;
    while (lrfd !== val && n < 200) begin
      @(negedge CLOCK_50);
      n++;
    end
    check(tag, {31'd0, lrfd}, {31'd0, val});
  endtask

  // One full cable transfer; LDAV held 'hold' cycles after capture then released
  task automatic send_word(input logic [DW-1:0] w, input int hold);
    int n = 0;
    wait_lrfd(1'b1, "lrfd_ready");
    data_in = w;
    ldav    = 1'b1;
    while (lrfd !== 1'b0 && n < 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("capture_latency", n, CAP_LAT);
    check("m_valid_before_push", {31'd0, m_valid}, {31'd0, (exp_q.size() != 0)});
    exp_q.push_back(w);
    exp_cnt++;
    @(negedge CLOCK_50);
    check("m_valid_after_push", {31'd0, m_valid}, 32'd1);
    check("word_cnt", {16'd0, word_cnt}, {16'd0, exp_cnt});
    data_in = DW'($urandom);
    repeat (hold) @(negedge CLOCK_50);
    ldav = 1'b0;
    check("no_timeout", {31'd0, timeout_err}, 32'd0);
  endtask

  task automatic pop_word(input string tag);
    logic [DW-1:0] e;
    e = exp_q.pop_front();
    check({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
    check(tag, {18'd0, m_data}, {18'd0, e});
    m_ready = 1'b1;
    @(negedge CLOCK_50);
    m_ready = 1'b0;
  endtask

  initial begin
    int            hi_seen;
    int            all_hi;
    logic [DW-1:0] w;

    // Clock/reset block
    rst_n   = 1'b0;
    enable  = 1'b0;
    ldav    = 1'b0;
    err_clr = 1'b0;
    m_ready = 1'b0;
    data_in = '0;
    exp_cnt = '0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_lrfd",    {31'd0, lrfd},        32'd0);
    check("rst_m_valid", {31'd0, m_valid},     32'd0);
    check("rst_m_data",  {18'd0, m_data},      32'd0);
    check("rst_word_cnt",{16'd0, word_cnt},    32'd0);
    check("rst_timeout", {31'd0, timeout_err}, 32'd0);
    check("rst_busy",    {31'd0, busy},        32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    check("disabled_idle", {31'd0, lrfd}, 32'd0);
    enable = 1'b1;

    // Single word
    send_word(14'h2A5B, 2);
    pop_word("single_word");

    // Back-pressure: four words fill the FIFO, LRFD must stay low
    for (int i = 0; i < DEPTH; i++) send_word(DW'($urandom), 2);
    hi_seen = 0;
    repeat (20) begin
      @(negedge CLOCK_50);
      if (lrfd) hi_seen = 1;
    end
    check("full_lrfd_low", hi_seen, 0);
    check("full_idle", {31'd0, busy}, 32'd0);
    pop_word("bp_pop0");
    wait_lrfd(1'b1, "bp_lrfd_reassert");
    send_word(DW'($urandom), 3);
    while (exp_q.size() != 0) pop_word("bp_order");

    // Glitch on LDAV shorter than the settle window
    wait_lrfd(1'b1, "glitch_ready");
    all_hi  = 1;
    data_in = 14'h1234;
    ldav    = 1'b1;
    repeat (3) begin
      @(negedge CLOCK_50);
      if (!lrfd) all_hi = 0;
    end
    ldav = 1'b0;
    repeat (20) begin
      @(negedge CLOCK_50);
      if (!lrfd) all_hi = 0;
    end
    check("glitch_lrfd_high", all_hi, 1);
    check("glitch_word_cnt", {16'd0, word_cnt}, {16'd0, exp_cnt});
    check("glitch_no_push", {31'd0, m_valid}, 32'd0);

    // Timeout: LDAV held long after capture
    wait_lrfd(1'b1, "tmo_ready");
    data_in = 14'h0F0F;
    ldav    = 1'b1;
    wait_lrfd(1'b0, "tmo_capture");
    exp_q.push_back(14'h0F0F);
    exp_cnt++;
    repeat (TIMEOUT_CYC / 2) @(negedge CLOCK_50);
    check("tmo_not_yet", {31'd0, timeout_err}, 32'd0);
    repeat (TIMEOUT_CYC / 2 + 10) @(negedge CLOCK_50);
    check("tmo_set", {31'd0, timeout_err}, 32'd1);
    check("tmo_busy", {31'd0, busy}, 32'd1);
    repeat (5) @(negedge CLOCK_50);
    check("tmo_sticky", {31'd0, timeout_err}, 32'd1);
    err_clr = 1'b1;
    @(negedge CLOCK_50);
    err_clr = 1'b0;
    check("tmo_cleared", {31'd0, timeout_err}, 32'd0);
    enable = 1'b0;
    ldav   = 1'b0;
    repeat (6) @(negedge CLOCK_50);
    check("tmo_back_idle", {31'd0, busy}, 32'd0);
    check("disabled_lrfd", {31'd0, lrfd}, 32'd0);
    check("tmo_word_cnt", {16'd0, word_cnt}, {16'd0, exp_cnt});
    enable = 1'b1;
    pop_word("tmo_word");

    // Asynchronous reset in the middle of SETTLE
    send_word(DW'($urandom), 1);
    wait_lrfd(1'b1, "rst_ready");
    data_in = 14'h3C3C;
    ldav    = 1'b1;
    repeat (6) @(negedge CLOCK_50);
    check("pre_rst_lrfd", {31'd0, lrfd}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_lrfd",    {31'd0, lrfd},    32'd0);
    check("async_rst_m_valid", {31'd0, m_valid}, 32'd0);
    exp_q.delete();
    exp_cnt = '0;
    repeat (2) @(negedge CLOCK_50);
    ldav  = 1'b0;
    rst_n = 1'b1;
    send_word(14'h0ABC, 2);
    pop_word("post_rst_word");

    // word_cnt wrap
    @(negedge CLOCK_50);
    force dut.word_cnt = 16'hFFFF;
    @(negedge CLOCK_50);
    release dut.word_cnt;
    exp_cnt = 16'hFFFF;
    send_word(DW'($urandom), 2);
    check("wrap_zero", {16'd0, word_cnt}, 32'd0);
    pop_word("wrap_word");

    // Randomized mix of transfers and pops against the queue model
    for (int i = 0; i < 24; i++) begin
      w = DW'($urandom);
      if (exp_q.size() != 0 && ($urandom_range(0, 2) == 0 || exp_q.size() == DEPTH))
        pop_word("rand_pop");
      else
        send_word(w, $urandom_range(1, 5));
    end
    while (exp_q.size() != 0) pop_word("drain_pop");
    @(negedge CLOCK_50);
    check("final_empty", {31'd0, m_valid}, 32'd0);
    check("final_word_cnt", {16'd0, word_cnt}, {16'd0, exp_cnt});
    check("final_timeout", {31'd0, timeout_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
